// File: rtl/cursor_input.sv
// cursor_input: button sync/debounce, auto-repeat cursor axes, button code.
// Define CURSOR_WRAP_EN to make cursor steps wrap around at the edges.

module cursor_axis #(
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int MAX           = 63,
  parameter int INIT          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       neg,
  input  logic       pos,
  output logic [5:0] coord,
  output logic       changed
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam logic [23:0] RD_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RP_LAST = 24'(REPEAT_PERIOD - 1);
  localparam logic [5:0]  C_MAX   = 6'(MAX);
  localparam logic [5:0]  C_INIT  = 6'(INIT);

  state_t      st, st_n;
  logic [1:0]  act, dir, dir_n;
  logic [23:0] cnt, cnt_n;
  logic        step;
  logic [5:0]  coord_n;

  // {pos, neg}; both or neither pressed means no direction
  assign act = {pos & ~neg, neg & ~pos};

  always_comb begin
    st_n  = st;
    dir_n = dir;
    cnt_n = cnt;
    step  = 1'b0;
    unique case (st)
      IDLE: begin
        if (act != 2'b00) begin
          step  = 1'b1;
          dir_n = act;
          cnt_n = '0;
          st_n  = DELAY;
        end
      end
      DELAY: begin
        if (act != dir) begin
          st_n = IDLE;
        end else if (cnt == RD_LAST) begin
          step  = 1'b1;
          cnt_n = '0;
          st_n  = REPEAT;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      REPEAT: begin
        if (act != dir) begin
          st_n = IDLE;
        end else if (cnt == RP_LAST) begin
          step  = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    coord_n = coord;
    if (step && dir_n[1]) begin
      if (coord != C_MAX) coord_n = coord + 6'd1;
`ifdef CURSOR_WRAP_EN
      else coord_n = '0;
`endif
    end else if (step && dir_n[0]) begin
      if (coord != 6'd0) coord_n = coord - 6'd1;
`ifdef CURSOR_WRAP_EN
      else coord_n = C_MAX;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      dir     <= '0;
      cnt     <= '0;
      coord   <= C_INIT;
      changed <= 1'b0;
    end else begin
      st      <= st_n;
      dir     <= dir_n;
      cnt     <= cnt_n;
      coord   <= coord_n;
      changed <= (coord_n != coord);
    end
  end
endmodule

module cursor_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int X_MAX           = 63,
  parameter int Y_MAX           = 63,
  parameter int X_INIT          = 32,
  parameter int Y_INIT          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_c,
  input  logic       btn_enter,
  input  logic       btn_pal,
  output logic [5:0] out_x,
  output logic [5:0] out_y,
  output logic [2:0] out_button,
  output logic       moved,
  output logic       press
);
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  // bit order: up, down, left, right, c, enter, pal
  logic [6:0]  raw, s1, s2, stb;
  logic [23:0] db_cnt [7];
  logic [2:0]  code_n;
  logic        x_chg, y_chg;

  assign raw = {btn_pal, btn_enter, btn_c, btn_right,
                btn_left, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      stb <= '0;
      for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 7; i++) begin
        if (s2[i] == stb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stb[i]    <= s2[i];
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != '1) begin
          db_cnt[i] <= db_cnt[i] + 24'd1;
        end
      end
    end
  end

  always_comb begin
    code_n = 3'b000;
    unique case (1'b1)
      stb[5] &  stb[6]: code_n = 3'b011;
      stb[5] & ~stb[6]: code_n = 3'b010;
      stb[4] & ~stb[5]: code_n = 3'b100;
      default:          code_n = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_button <= 3'b000;
      press      <= 1'b0;
    end else begin
      out_button <= code_n;
      press      <= (code_n != out_button) && (code_n != 3'b000);
    end
  end

  cursor_axis #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
    .MAX(X_MAX), .INIT(X_INIT)
  ) u_x (
    .clk(clk), .rst(rst), .neg(stb[2]), .pos(stb[3]),
    .coord(out_x), .changed(x_chg)
  );

  cursor_axis #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
    .MAX(Y_MAX), .INIT(Y_INIT)
  ) u_y (
    .clk(clk), .rst(rst), .neg(stb[0]), .pos(stb[1]),
    .coord(out_y), .changed(y_chg)
  );

  assign moved = x_chg | y_chg;
endmodule

// File: tb/tb_cursor_input.sv
// tb_cursor_input: vector table plus multi-cycle sequences, queue scoreboard.
// Expected values follow the documented edge timing (D=4, delay 10, period 3).

module tb_cursor_input;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic       btn_c = 0, btn_enter = 0, btn_pal = 0;
  logic [5:0] out_x, out_y;
  logic [2:0] out_button;
  logic       moved, press;

  int n_pass = 0;
  int n_tot  = 0;

  cursor_input #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_c(btn_c), .btn_enter(btn_enter), .btn_pal(btn_pal),
    .out_x(out_x), .out_y(out_y), .out_button(out_button),
    .moved(moved), .press(press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] btn;  // {pal, enter, c, right, left, down, up}
    int         eb;
    int         dx;
    int         dy;
  } vec_t;

  typedef struct {
    string nm;
    int    x, y, b, m, p;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [6:0] b);
    {btn_pal, btn_enter, btn_c, btn_right,
     btn_left, btn_down, btn_up} = b;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push(input string nm, input int x, input int y,
                      input int b, input int m, input int p);
    exp_t e;
    e.nm = nm; e.x = x; e.y = y; e.b = b; e.m = m; e.p = p;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL sb_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk({e.nm, ".x"}, int'(out_x), e.x);
    chk({e.nm, ".y"}, int'(out_y), e.y);
    chk({e.nm, ".btn"}, int'(out_button), e.b);
    chk({e.nm, ".moved"}, int'(moved), e.m);
    chk({e.nm, ".press"}, int'(press), e.p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_btn(7'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // number of steps taken k edges after a direction is raw-pressed
  function automatic int steps(input int k);
    if (k < 7) return 0;
    if (k < 17) return 1;
    return 2 + (k - 17) / 3;
  endfunction

  function automatic int exp_coord(input int start, input int sgn,
                                   input int n);
    int v;
    v = start + sgn * n;
`ifdef CURSOR_WRAP_EN
    v = ((v % 64) + 64) % 64;
`else
    if (v > 63) v = 63;
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  task automatic run_hold(input logic [6:0] b, input bit is_y,
                          input int sgn, input int cycles,
                          input string nm);
    int v, prev;
    do_reset();
    set_btn(b);
    prev = 32;
    for (int k = 1; k <= cycles; k++) begin
      v = exp_coord(32, sgn, steps(k));
      push($sformatf("%s@%0d", nm, k), is_y ? 32 : v, is_y ? v : 32,
           0, int'(v != prev), 0);
      tick();
      pop_cmp();
      prev = v;
    end
    set_btn(7'b0);
  endtask

  initial begin
    vecs[0]  = '{7'b0010000, 4, 0, 0};
    vecs[1]  = '{7'b0100000, 2, 0, 0};
    vecs[2]  = '{7'b1100000, 3, 0, 0};
    vecs[3]  = '{7'b1000000, 0, 0, 0};
    vecs[4]  = '{7'b0110000, 2, 0, 0};
    vecs[5]  = '{7'b1110000, 3, 0, 0};
    vecs[6]  = '{7'b1010000, 4, 0, 0};
    vecs[7]  = '{7'b0001000, 0, 1, 0};
    vecs[8]  = '{7'b0001101, 0, 0, -1};
    vecs[9]  = '{7'b0000110, 0, -1, 1};
    vecs[10] = '{7'b0000011, 0, 0, 0};

    // reset state
    push("reset", 32, 32, 0, 0, 0);
    tick();
    tick();
    pop_cmp();
    rst = 1'b0;

    // single press: no change at edge 6, change plus pulse at edge 7
    foreach (vecs[i]) begin
      int mv;
      mv = int'(vecs[i].dx != 0 || vecs[i].dy != 0);
      do_reset();
      set_btn(vecs[i].btn);
      for (int k = 1; k <= 6; k++) tick();
      push($sformatf("vec%0d@6", i), 32, 32, 0, 0, 0);
      pop_cmp();
      tick();
      push($sformatf("vec%0d@7", i), 32 + vecs[i].dx, 32 + vecs[i].dy,
           vecs[i].eb, mv, int'(vecs[i].eb != 0));
      pop_cmp();
      tick();
      push($sformatf("vec%0d@8", i), 32 + vecs[i].dx, 32 + vecs[i].dy,
           vecs[i].eb, 0, 0);
      pop_cmp();
      set_btn(7'b0);
    end

    // glitch of 3 cycles is filtered, then a 20-cycle hold and release
    do_reset();
    set_btn(7'b0010000);
    for (int k = 1; k <= 3; k++) tick();
    set_btn(7'b0);
    for (int k = 4; k <= 12; k++) begin
      push($sformatf("glitch@%0d", k), 32, 32, 0, 0, 0);
      tick();
      pop_cmp();
    end
    set_btn(7'b0010000);
    for (int k = 1; k <= 20; k++) begin
      push($sformatf("c_hold@%0d", k), 32, 32,
           k >= 7 ? 4 : 0, 0, int'(k == 7));
      tick();
      pop_cmp();
    end
    set_btn(7'b0);
    for (int k = 1; k <= 9; k++) begin
      push($sformatf("c_rel@%0d", k), 32, 32, k >= 7 ? 0 : 4, 0, 0);
      tick();
      pop_cmp();
    end

    // auto-repeat up to the high x boundary, and down to y = 0
    run_hold(7'b0001000, 1'b0, 1, 130, "right");
    run_hold(7'b0000001, 1'b1, -1, 120, "up");

    // reversal left -> right: one idle cycle before the first right step
    do_reset();
    set_btn(7'b0000100);
    for (int k = 1; k <= 9; k++) tick();
    push("rev_pre", 31, 32, 0, 0, 0);
    pop_cmp();
    set_btn(7'b0001000);
    for (int r = 1; r <= 10; r++) begin
      push($sformatf("rev@%0d", r), r >= 8 ? 32 : 31, 32, 0,
           int'(r == 8), 0);
      tick();
      pop_cmp();
    end
    set_btn(7'b0);

    // reset while enter+pal held: code drops, returns after re-debounce
    do_reset();
    set_btn(7'b1100000);
    for (int k = 1; k <= 8; k++) tick();
    push("rst_mid_pre", 32, 32, 3, 0, 0);
    pop_cmp();
    rst = 1'b1;
    tick();
    push("rst_mid_in", 32, 32, 0, 0, 0);
    pop_cmp();
    tick();
    rst = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      push($sformatf("rst_mid@%0d", r), 32, 32,
           r >= 7 ? 3 : 0, 0, int'(r == 7));
      tick();
      pop_cmp();
    end
    set_btn(7'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
